// File: rtl/keystream_xor.sv
// ---------------------------------------------------------------------------
// keystream_xor
//
// Purpose:
//   Turns the sawtooth chaotic-map results (IEEE-754 single in [0,1)) into
//   8-bit key bytes, buffers them in a small FIFO and XORs them, one key per
//   pixel and strictly in arrival order, into a pixel byte stream.
//   The sawtooth pipeline cannot be stalled, so the FIFO absorbs its output
//   and key_afull tells the iteration controller to stop issuing new work
//   early enough that nothing in flight is lost.
//
// Optional feature (macro KEYSTREAM_CHAIN_EN):
//   Adds a cipher-feedback byte prev: out = pixel ^ key ^ prev, prev takes
//   each produced output byte and is cleared after a pixel with tlast so
//   every image starts from prev = 0. Without the macro it is a plain XOR
//   and no prev register exists.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   key_tvalid, key_in  one-cycle pulse carrying a sawtooth float result
//   key_afull           free FIFO entries < AFULL_MARGIN
//   pixel_t*            input pixel stream (valid/ready/data/last)
//   out_t*              output cipher stream (valid/ready/data/last)
//   overflow            sticky: a key byte was dropped on a full FIFO
//   range_err           sticky: a key had exponent >= 127 (|x| >= 1, NaN, Inf)
//
// Handshake: a beat moves on a channel in the cycle where tvalid and tready
// are both high at the rising edge. out_tvalid, once high, stays high with
// out_tdata/out_tlast stable until out_tready is seen; pixel_tready never
// depends on pixel_tvalid.
// ---------------------------------------------------------------------------
module keystream_xor #(
    parameter int PRECISION    = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_tvalid,
    input  logic [PRECISION-1:0] key_in,
    output logic                 key_afull,
    input  logic                 pixel_tvalid,
    output logic                 pixel_tready,
    input  logic [7:0]           pixel_tdata,
    input  logic                 pixel_tlast,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic [7:0]           out_tdata,
    output logic                 out_tlast,
    output logic                 overflow,
    output logic                 range_err
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Quantiser (combinational part): byte = floor(|x| * 256)
    // ------------------------------------------------------------------
    logic [30:0] key_mag;     // key with the sign stripped
    logic [7:0]  key_exp;
    logic [23:0] key_mant;    // mantissa with the hidden 1
    logic [7:0]  key_shamt;
    logic [7:0]  q_byte;
    logic        q_err;

    always_comb begin
        key_mag   = 31'(key_in & {1'b0, {(PRECISION-1){1'b1}}});
        key_exp   = key_mag[30:23];
        key_mant  = {1'b1, key_mag[22:0]};
        // |x|*256 = M * 2^(e-142); only meaningful for 119 <= e <= 126
        key_shamt = 8'd142 - key_exp;
        q_byte    = 8'h00;
        q_err     = 1'b0;
        if (key_exp >= 8'd127) begin
            q_byte = 8'hFF;
            q_err  = 1'b1;
        end else if (key_exp >= 8'd119) begin
            q_byte = 8'(key_mant >> key_shamt);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          qv_q, qv_d;
    logic [7:0]    qbyte_q, qbyte_d;
    logic          range_err_q, range_err_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          out_tvalid_q, out_tvalid_d;
    logic [7:0]    out_tdata_q, out_tdata_d;
    logic          out_tlast_q, out_tlast_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          fifo_full;
    logic          fifo_wr;
    logic          accept;
    logic [7:0]    rd_key;
    logic [7:0]    cipher;

`ifdef KEYSTREAM_CHAIN_EN
    logic [7:0]    prev_q, prev_d;
`endif

    always_comb begin
        fifo_full    = (count_q == DEPTH_CNT);
        rd_key       = mem_q[rd_ptr_q];
        pixel_tready = (count_q != '0) && (!out_tvalid_q || out_tready);
        accept       = pixel_tvalid && pixel_tready;
        key_afull    = (FIFO_DEPTH - int'(count_q)) < AFULL_MARGIN;

`ifdef KEYSTREAM_CHAIN_EN
        cipher       = pixel_tdata ^ rd_key ^ prev_q;
`else
        cipher       = pixel_tdata ^ rd_key;
`endif

        // Quantiser register stage
        qv_d        = key_tvalid;
        qbyte_d     = key_tvalid ? q_byte : qbyte_q;
        range_err_d = range_err_q | (key_tvalid & q_err);

        // A pop in the same cycle frees the slot, so a write into a full
        // FIFO only drops when no pixel is accepted alongside it.
        fifo_wr    = qv_q && (!fifo_full || accept);
        overflow_d = overflow_q | (qv_q && fifo_full && !accept);

        wr_ptr_d = fifo_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = accept  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (fifo_wr && !accept) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!fifo_wr && accept) begin
            count_d = count_q - (AW+1)'(1);
        end

        // Output register: load on accept, else retire on handshake
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        if (accept) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = cipher;
            out_tlast_d  = pixel_tlast;
        end else if (out_tready) begin
            out_tvalid_d = 1'b0;
        end

`ifdef KEYSTREAM_CHAIN_EN
        prev_d = prev_q;
        if (accept) begin
            prev_d = pixel_tlast ? 8'h00 : cipher;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qv_q         <= 1'b0;
            qbyte_q      <= 8'h00;
            range_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= 8'h00;
            out_tlast_q  <= 1'b0;
        end else begin
            qv_q         <= qv_d;
            qbyte_q      <= qbyte_d;
            range_err_q  <= range_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
        end
    end

`ifdef KEYSTREAM_CHAIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= qbyte_q;
        end
    end

    assign out_tvalid = out_tvalid_q;
    assign out_tdata  = out_tdata_q;
    assign out_tlast  = out_tlast_q;
    assign overflow   = overflow_q;
    assign range_err  = range_err_q;

endmodule

// File: doc/keystream_xor.md
Name: keystream_xor

Overview:
- Downstream consumer of the sawtooth chaotic-map stage.
- Takes each IEEE-754 single-precision sawtooth result in [0,1) and quantises it to an 8-bit key byte.
- Buffers key bytes in a FIFO and XORs them with an incoming pixel stream to produce cipher (or plain) pixels.
- Decouples the free-running sawtooth pipeline, which has no backpressure, from the pixel AXI-Stream-style interfaces; key_afull throttles the iteration controller.

Parameters:
- PRECISION, 32: width of the float key input; only 32 is supported.
- FIFO_DEPTH, 16: key-byte FIFO entries; must be a power of 2, ≥4.
- AFULL_MARGIN, 8: key_afull asserts when the FIFO has fewer than this many free entries. Covers sawtooth pipeline latency plus the quantiser stage.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- key_tvalid  in  1  sawtooth result valid (one-cycle pulse per result)
- key_in  in  PRECISION  sawtooth result, IEEE-754 single
- key_afull  out  1  FIFO almost full; controller must stop issuing sawtooth_tvalid
- pixel_tvalid  in  1  input pixel valid
- pixel_tready  out  1  input pixel accepted when high with tvalid
- pixel_tdata  in  8  input pixel byte
- pixel_tlast  in  1  last pixel of image
- out_tvalid  out  1  output byte valid
- out_tready  in  1  downstream ready
- out_tdata  out  8  pixel XOR key
- out_tlast  out  1  registered copy of pixel_tlast
- overflow  out  1  sticky: a key was dropped because the FIFO was full
- range_err  out  1  sticky: a key had exponent ≥127 (|x| ≥ 1.0), or was NaN/Inf

Behaviour:
- **Reset (async, reset_n low):** FIFO emptied (pointers and count = 0). key_afull=0, pixel_tready=0, out_tvalid=0, out_tdata=0, out_tlast=0, overflow=0, range_err=0, quantiser valid=0. Reset mid-stream discards all buffered keys and any pending output.
- **Quantiser (1 registered stage):** key byte = floor(|x|·256), with s=key_in[31], e=key_in[30:23], M={1,key_in[22:0]}.
  - e<119: byte=0.
  - 119≤e≤126: byte=M>>(142−e), low 8 bits.
  - e≥127: byte=8'hFF, range_err←1.
  - Sign is ignored (absolute value).
  - Denormals and zero fall under e<119, giving 0.
- **FIFO write:** occurs the cycle after key_tvalid.
  - Full at write time: byte dropped, overflow←1, count unchanged.
  - Simultaneous write and read when full: the read frees a slot, so the write succeeds with no overflow.
- **key_afull** = (FIFO_DEPTH − count) < AFULL_MARGIN. Combinational from the registered count.
- **pixel_tready** = FIFO non-empty AND (out_tvalid==0 OR out_tready==1).
- **Pixel acceptance:** on pixel_tvalid & pixel_tready:
  - Pop one key byte.
  - Next cycle: out_tdata = pixel_tdata ^ key, out_tlast = pixel_tlast, out_tvalid = 1.
  - Latency is 1 cycle; full throughput of 1 pixel/cycle while keys are available.
- **Output hold:** out_tvalid & !out_tready holds out_tdata/out_tlast stable. out_tvalid drops after a handshake with no new accept.
- **Empty FIFO:** pixel_tready=0; pixels stall and are never XORed with a stale key.
- **Key ordering:** keys are consumed strictly in arrival order. One key per pixel; keys are never reused.

Optional Feature:
- Macro: KEYSTREAM_CHAIN_EN.
- When defined, a cipher-feedback register prev (reset 0) is added:
  - out_tdata = pixel ^ key ^ prev.
  - prev ← out_tdata on each accepted pixel.
  - prev ← 0 after accepting a pixel with tlast=1, so each image starts fresh.
- When undefined: plain XOR; no prev register is synthesised.

Test Plan:
- Quantiser spot checks; each key is followed by a pixel 0x00 to expose the key byte:
  - key_in 0x3F400000 (0.75) → 0xC0
  - 0x3F000000 (0.5) → 0x80
  - 0x3D4CCCCD (0.05) → 0x0C
  - 0x3A83126F (0.001) → 0x00
  - 0xBF400000 (−0.75) → 0xC0
- Range error: key_in 0x3FE00000 (1.75) → key byte 0xFF; range_err sticks at 1 until reset.
- XOR path: keys 0.75 then 0.5, pixels 0xA5 then 0x3C with out_tready=1 → out_tdata 0x65 then 0xBC, one cycle after each accept; tlast propagated on the second.
- Backpressure and stall:
  - out_tready=0 for 5 cycles → output held, pixel_tready=0.
  - FIFO empty with pixel_tvalid=1 → pixel_tready=0 until a key arrives, then accept on the following cycle.
- Overflow and afull, with defaults:
  - Push 8 keys with no pixels → key_afull=0 (8 free entries, not < 8).
  - Push a 9th key → key_afull=1.
  - Push to 16 keys, then a 17th → overflow=1, count stays 16.
  - Async reset_n pulse mid-stream → all outputs return to reset values immediately.
- KEYSTREAM_CHAIN_EN: keys 0xC0, 0x80, 0xC0 with pixels 0xA5, 0x3C(tlast), 0xA5 → outputs 0x65, 0xD9, 0x65 (prev cleared after tlast).
